dcache_writeline_burst: RTL and testbench

Data-cache write-back engine directly downstream of the data-cache control RAM's write-line request port. It accepts one dirty 128-bit line plus its physical address, emits it as a 4-beat Avalon-MM burst write of 32-bit words, and answers the control RAM with a single-cycle `writeline_done`. It serves both normal evictions and the WBINVD flush walk.

---
 rtl/dcache_writeline_burst.sv | 99 +++++++++
 tb/tb_dcache_writeline_burst.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_writeline_burst.sv
// Write-back engine: turns one dirty 128-bit cache line into a 4-beat Avalon-MM burst write.
// Define DCACHE_WRITELINE_POSTED_EN to release upstream at the first beat instead of after the last.
module dcache_writeline_burst (
  input  logic         clk,
  input  logic         rst,
  input  logic         writeline_do,
  input  logic [31:0]  writeline_address,
  input  logic [127:0] writeline_line,
  output logic         writeline_done,
  output logic         drained,
  output logic [29:0]  avm_address,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  output logic [3:0]   avm_byteenable,
  output logic [2:0]   avm_burstcount,
  input  logic         avm_waitrequest
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t       state;
  logic [1:0]   beat;
  logic [1:0]   beat_nxt;
  logic [127:0] line_q;
  logic [1:0]   addr_unused;

  assign beat_nxt       = beat + 2'd1;
  assign avm_burstcount = 3'd4;
  assign addr_unused    = writeline_address[1:0];

  // Every output is registered; address and data come only from the captured copy of the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      beat           <= 2'd0;
      line_q         <= '0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= 4'h0;
      writeline_done <= 1'b0;
      drained        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (writeline_do) begin
            state          <= BURST;
            beat           <= 2'd0;
            line_q         <= writeline_line;
            avm_address    <= writeline_address[31:2];
            avm_writedata  <= writeline_line[31:0];
            avm_write      <= 1'b1;
            avm_byteenable <= 4'hF;
            drained        <= 1'b0;
`ifdef DCACHE_WRITELINE_POSTED_EN
            writeline_done <= 1'b1;
`endif
          end
        end

        BURST: begin
`ifdef DCACHE_WRITELINE_POSTED_EN
          writeline_done <= 1'b0;
`endif
          if (!avm_waitrequest) begin
            if (beat == 2'd3) begin
              avm_write      <= 1'b0;
              avm_byteenable <= 4'h0;
              avm_address    <= '0;
              avm_writedata  <= '0;
`ifdef DCACHE_WRITELINE_POSTED_EN
              state          <= IDLE;
              drained        <= 1'b1;
`else
              state          <= DONE;
              writeline_done <= 1'b1;
`endif
            end else begin
              beat          <= beat_nxt;
              avm_writedata <= line_q[{beat_nxt, 5'd0} +: 32];
            end
          end
        end

        // Upstream still holds the finished request here, so writeline_do must not be sampled.
        DONE: begin
          writeline_done <= 1'b0;
          drained        <= 1'b1;
          state          <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_writeline_burst.sv
// Self-checking bench for dcache_writeline_burst: vector table, random lines and a mid-burst reset.
// Follows DCACHE_WRITELINE_POSTED_EN when the design is built with it.
module tb_dcache_writeline_burst;

`ifdef DCACHE_WRITELINE_POSTED_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         writeline_do;
  logic [31:0]  writeline_address;
  logic [127:0] writeline_line;
  logic         writeline_done;
  logic         drained;
  logic [29:0]  avm_address;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic [3:0]   avm_byteenable;
  logic [2:0]   avm_burstcount;
  logic         avm_waitrequest;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] line;
    logic [63:0]  mask;
    int           exp_fin;
    bit           hold;
  } vec_t;

  vec_t vecs[$];

  dcache_writeline_burst dut (
    .clk               (clk),
    .rst               (rst),
    .writeline_do      (writeline_do),
    .writeline_address (writeline_address),
    .writeline_line    (writeline_line),
    .writeline_done    (writeline_done),
    .drained           (drained),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timing: the cycle after the fourth accepted beat, counting T1 as the first beat cycle.
  function automatic int model_fin(input logic [63:0] mask);
    int acc = 0;
    int k = 0;
    while (acc < 4) begin
      if (!mask[k]) acc++;
      k++;
    end
    return k + 1;
  endfunction

  // Drives one request from T0 and checks every cycle until the engine is ready for the next one.
  task automatic applyStimulus(input logic [31:0] a, input logic [127:0] l, input logic [63:0] mask,
                               input int exp_fin, input bit hold,
                               input logic [31:0] na, input logic [127:0] nl);
    int  acc = 0;
    int  fin = 0;
    int  rdy = 0;
    bit  ended = 1'b0;
    checkOutput("t0_drained", 32'(drained), 32'd1);
    checkOutput("t0_write", 32'(avm_write), 32'd0);
    writeline_do      = 1'b1;
    writeline_address = a;
    writeline_line    = l;
    avm_waitrequest   = 1'b0;
    for (int k = 1; k <= 40 && !ended; k++) begin
      tick();
      if (acc == 4 && fin == 0) begin
        fin = k;
        rdy = POSTED ? k : k + 1;
        checkOutput("fin_cycle", 32'(k), 32'(exp_fin));
      end
      if (acc < 4) begin
        checkOutput("burst_write", 32'(avm_write), 32'd1);
        checkOutput("burst_addr", 32'(avm_address), 32'(a[31:2]));
        checkOutput("burst_data", avm_writedata, l[acc*32 +: 32]);
        checkOutput("burst_be", 32'(avm_byteenable), 32'hF);
        checkOutput("burst_count", 32'(avm_burstcount), 32'd4);
        checkOutput("burst_drained", 32'(drained), 32'd0);
        checkOutput("burst_done", 32'(writeline_done), 32'(POSTED && k == 1));
        avm_waitrequest   = mask[k-1];
        writeline_do      = POSTED ? (hold && k >= 2) : 1'b1;
        writeline_address = (POSTED && hold && k >= 2) ? na : ($urandom() & 32'hFFFF_FFF0);
        writeline_line    = (POSTED && hold && k >= 2) ? nl :
                            {$urandom(), $urandom(), $urandom(), $urandom()};
        if (!mask[k-1]) acc++;
      end else if (k < rdy) begin
        checkOutput("done_pulse", 32'(writeline_done), 32'd1);
        checkOutput("done_write", 32'(avm_write), 32'd0);
        checkOutput("done_be", 32'(avm_byteenable), 32'h0);
        checkOutput("done_drained", 32'(drained), 32'd0);
        avm_waitrequest   = 1'b0;
        writeline_do      = hold;
        writeline_address = a;
        writeline_line    = l;
      end else begin
        checkOutput("rdy_drained", 32'(drained), 32'd1);
        checkOutput("rdy_write", 32'(avm_write), 32'd0);
        checkOutput("rdy_done", 32'(writeline_done), 32'd0);
        avm_waitrequest   = 1'b0;
        writeline_do      = hold;
        writeline_address = POSTED ? na : a;
        writeline_line    = POSTED ? nl : l;
        ended = 1'b1;
      end
    end
    checkOutput("request_timeout", 32'(ended), 32'd1);
  endtask

  initial begin
    rst               = 1'b1;
    writeline_do      = 1'b0;
    writeline_address = '0;
    writeline_line    = '0;
    avm_waitrequest   = 1'b0;

    vecs.push_back('{32'h0001_2340, 128'h44444444_33333333_22222222_11111111, 64'h0, 5, 1'b0});
    vecs.push_back('{32'h0001_2340, 128'h44444444_33333333_22222222_11111111, 64'h13, 8, 1'b0});
    vecs.push_back('{32'h0ABC_DEF0, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 64'h0, 5, 1'b1});
    vecs.push_back('{32'hFFFF_FFF0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 64'h5, 7, 1'b0});
    vecs.push_back('{32'h0000_0000, 128'h0F0F0F0F_F0F0F0F0_FFFFFFFF_00000000, 64'h8, 6, 1'b0});
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v.addr    = $urandom() & 32'hFFFF_FFF0;
      v.line    = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.mask    = 64'($urandom_range(0, 4095)) & 64'($urandom_range(0, 4095));
      v.exp_fin = model_fin(v.mask);
      v.hold    = ($urandom_range(0, 1) == 1);
      vecs.push_back(v);
    end
    vecs[vecs.size()-1].hold = 1'b0;

    tick();
    tick();
    checkOutput("rst_write", 32'(avm_write), 32'd0);
    checkOutput("rst_done", 32'(writeline_done), 32'd0);
    checkOutput("rst_drained", 32'(drained), 32'd1);
    checkOutput("rst_be", 32'(avm_byteenable), 32'h0);
    checkOutput("rst_addr", 32'(avm_address), 32'd0);
    checkOutput("rst_data", avm_writedata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle_write", 32'(avm_write), 32'd0);
      checkOutput("idle_done", 32'(writeline_done), 32'd0);
      checkOutput("idle_drained", 32'(drained), 32'd1);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0]  na;
      logic [127:0] nl;
      na = (i + 1 < vecs.size()) ? vecs[i+1].addr : 32'd0;
      nl = (i + 1 < vecs.size()) ? vecs[i+1].line : 128'd0;
      applyStimulus(vecs[i].addr, vecs[i].line, vecs[i].mask, vecs[i].exp_fin, vecs[i].hold, na, nl);
    end

    // Reset lands after beat 1 has been accepted; the burst must be abandoned cleanly.
    writeline_do      = 1'b1;
    writeline_address = 32'h0005_5550;
    writeline_line    = 128'h13131313_12121212_11111111_10101010;
    avm_waitrequest   = 1'b0;
    tick();
    tick();
    checkOutput("mid_beat1_data", avm_writedata, 32'h11111111);
    tick();
    rst          = 1'b1;
    writeline_do = 1'b0;
    tick();
    checkOutput("mid_rst_write", 32'(avm_write), 32'd0);
    checkOutput("mid_rst_done", 32'(writeline_done), 32'd0);
    checkOutput("mid_rst_drained", 32'(drained), 32'd1);
    checkOutput("mid_rst_data", avm_writedata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_rst_done", 32'(writeline_done), 32'd0);
      checkOutput("post_rst_write", 32'(avm_write), 32'd0);
    end
    applyStimulus(32'h0007_7770, 128'h23232323_22222222_21212121_20202020, 64'h0, 5, 1'b0,
                  32'd0, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
